// File: rtl/lx32_arch_pkg.sv
// LX32 architectural constants, encoder formats and error codes.
// Also holds the put_*_imm helpers, which scatter an immediate into its RV32 bit positions.
package lx32_arch_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } insn_fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_OPCODE = 2'd1,
        ERR_RANGE  = 2'd2,
        ERR_ALIGN  = 2'd3
    } err_code_e;

    // One FIFO entry: 2 + 32 + 32 = 66 bits.
    typedef struct packed {
        err_code_e   err_code;
        logic [31:0] addr;
        logic [31:0] insn;
    } out_entry_t;

    function automatic insn_fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            default:                  return FMT_BAD;
        endcase
    endfunction

    // Each helper returns a word with only the immediate bits populated.
    function automatic logic [31:0] put_i_imm(input logic [11:0] imm);
        return {imm[11:0], 20'b0};
    endfunction

    function automatic logic [31:0] put_s_imm(input logic [11:0] imm);
        return {imm[11:5], 13'b0, imm[4:0], 7'b0};
    endfunction

    function automatic logic [31:0] put_b_imm(input logic [12:1] imm);
        return {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
    endfunction

    function automatic logic [31:0] put_u_imm(input logic [31:12] imm);
        return {imm[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] put_j_imm(input logic [20:1] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
    endfunction

endpackage

// File: rtl/lx32_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with flush.
// Latency: write at edge N is visible on rd_dat after edge N; pop does not free space for a same-cycle push.
// Backpressure: full blocks writes; flush empties and drops any same-edge push/pop.
module lx32_sync_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             empty, push, pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign rd_vld = !empty;
    assign push   = wr_vld && !full && !flush;
    assign pop    = rd_rdy && !empty && !flush;
    // When empty, present the last head so the outputs hold their value.
    assign rd_dat = empty ? hold_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = rd_dat;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/lx32_insn_encoder.sv
// Streaming RV32 encoder: range-checks and packs fields, tags with a word address, queues in a FWFT FIFO.
// Latency: combinational encode, written at the accepting edge; out_valid the next cycle when empty.
// Backpressure: req_ready drops when the FIFO is full or flush is high; outputs hold while out_ready is low.
module lx32_insn_encoder
    import lx32_arch_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_opcode,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_imm,
    input  logic        addr_load,
    input  logic [31:0] addr_load_val,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [1:0]  out_err_code,
    output logic [7:0]  err_cnt
);

    logic               fifo_full;
    logic               push;
    insn_fmt_e          fmt;
    err_code_e          err_code;
    logic signed [31:0] simm;
    logic [31:0]        insn_raw;
    logic [31:0]        ld_val;
    out_entry_t         push_entry;
    out_entry_t         head;
    logic [31:0]        addr_q, addr_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    assign req_ready = !fifo_full && !flush;
    assign push      = req_valid && req_ready;
    assign simm      = signed'(req_imm);
    assign ld_val    = addr_load_val & ~32'h3;

    always_comb begin
        fmt      = fmt_of(req_opcode);
        err_code = ERR_NONE;
        insn_raw = '0;
        case (fmt)
            FMT_I: begin
                if (simm < -32'sd2048 || simm > 32'sd2047) err_code = ERR_RANGE;
                insn_raw = put_i_imm(req_imm[11:0])
                         | {12'b0, req_rs1, req_funct3, req_rd, req_opcode};
            end
            FMT_S: begin
                if (simm < -32'sd2048 || simm > 32'sd2047) err_code = ERR_RANGE;
                insn_raw = put_s_imm(req_imm[11:0])
                         | {7'b0, req_rs2, req_rs1, req_funct3, 5'b0, req_opcode};
            end
            FMT_B: begin
                // Range beats alignment when both are violated.
                if (simm < -32'sd4096 || simm > 32'sd4094) err_code = ERR_RANGE;
                else if (req_imm[0])                      err_code = ERR_ALIGN;
                insn_raw = put_b_imm(req_imm[12:1])
                         | {7'b0, req_rs2, req_rs1, req_funct3, 5'b0, req_opcode};
            end
            FMT_U: begin
                if (req_imm[11:0] != 12'h0) err_code = ERR_ALIGN;
                insn_raw = put_u_imm(req_imm[31:12]) | {20'b0, req_rd, req_opcode};
            end
            FMT_J: begin
                if (simm < -32'sd1048576 || simm > 32'sd1048574) err_code = ERR_RANGE;
                else if (req_imm[0])                            err_code = ERR_ALIGN;
                insn_raw = put_j_imm(req_imm[20:1]) | {20'b0, req_rd, req_opcode};
            end
            default: err_code = ERR_OPCODE;
        endcase

        push_entry.err_code = err_code;
        push_entry.addr     = addr_q;
        push_entry.insn     = (err_code == ERR_NONE) ? insn_raw : NOP_INSN;
    end

    always_comb begin
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        if (addr_load)  addr_d = ld_val;
        else if (push)  addr_d = addr_q + 32'd4;
        if (push && err_code != ERR_NONE && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= RESET_ADDR;
            err_cnt_q <= '0;
        end else begin
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    lx32_sync_fifo #(
        .WIDTH ($bits(out_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wr_vld (push),
        .wr_dat (push_entry),
        .full   (fifo_full),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head)
    );

    assign out_insn     = head.insn;
    assign out_addr     = head.addr;
    assign out_err_code = head.err_code;
    assign out_err      = (head.err_code != ERR_NONE);
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_lx32_insn_encoder.sv
// Directed and randomized bench for lx32_insn_encoder against a rule-level reference model.
module tb_lx32_insn_encoder;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready;
    logic [6:0]  req_opcode;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [31:0] req_imm, addr_load_val;
    logic        addr_load, flush, out_valid, out_ready, out_err;
    logic [31:0] out_insn, out_addr;
    logic [1:0]  out_err_code;
    logic [7:0]  err_cnt;

    lx32_insn_encoder #(.FIFO_DEPTH(4), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_imm(req_imm), .addr_load(addr_load),
        .addr_load_val(addr_load_val), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_insn(out_insn), .out_addr(out_addr),
        .out_err(out_err), .out_err_code(out_err_code), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] addr;
    } req_t;

    req_t        model_q[$];
    logic [31:0] model_addr;
    int          model_errs;
    int          n_pass  = 0;
    int          n_total = 0;
    logic [6:0]  ops [9];
    logic [31:0] bnd [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Error code from the architectural rules, on signed integers.
    function automatic int exp_code(input logic [6:0] op, input logic [31:0] imm);
        int s;
        s = int'(imm);
        case (op)
            7'h13, 7'h03, 7'h67, 7'h23: return (s < -2048 || s > 2047) ? 2 : 0;
            7'h63: begin
                if (s < -4096 || s > 4094) return 2;
                return (s % 2 != 0) ? 3 : 0;
            end
            7'h6F: begin
                if (s < -1048576 || s > 1048574) return 2;
                return (s % 2 != 0) ? 3 : 0;
            end
            7'h37, 7'h17: return (imm % 4096 != 0) ? 3 : 0;
            default: return 1;
        endcase
    endfunction

    // Recover the immediate from an encoded word by weighted sums of its fields.
    function automatic logic [31:0] dec_imm(input logic [6:0] op, input logic [31:0] w);
        int top;
        top = ($signed(w) < 0) ? -1 : 0;
        case (op)
            7'h23: return 32'(top * 4096 + int'(w[30:25]) * 32 + int'(w[11:7]) + int'(w[31]) * 2048);
            7'h63: return 32'(top * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
            7'h37, 7'h17: return w & 32'hFFFF_F000;
            7'h6F: return 32'(top * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                              + int'(w[30:21]) * 2);
            default: return 32'($signed(w) >>> 20);
        endcase
    endfunction

    task automatic push_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        int   n;
        req_t e;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_before_push", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_opcode = op; req_rd = rd; req_rs1 = rs1;
        req_rs2 = rs2; req_funct3 = f3; req_imm = imm;
        e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.imm = imm;
        e.addr = model_addr;
        step();
        req_valid = 1'b0;
        model_q.push_back(e);
        if (exp_code(op, imm) != 0 && model_errs < 255) model_errs++;
        model_addr = addr_load ? (addr_load_val & ~32'h3) : model_addr + 32'd4;
    endtask

    task automatic pop_chk(input bit has_exp, input logic [31:0] exp_insn);
        int   n, code;
        req_t e;
        bit   is_sb, is_uj;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("out_valid_before_pop", 32'(out_valid), 32'd1);
        n_total++;
        assert (model_q.size() != 0) n_pass++;
        else $error("FAIL model_queue: observed empty expected an entry");
        if (model_q.size() != 0) begin
            e     = model_q.pop_front();
            code  = exp_code(e.op, e.imm);
            is_sb = (e.op == 7'h23 || e.op == 7'h63);
            is_uj = (e.op == 7'h37 || e.op == 7'h17 || e.op == 7'h6F);
            chk("err_code", 32'(out_err_code), 32'(code));
            chk("err_flag", 32'(out_err), 32'(code != 0));
            chk("addr", out_addr, e.addr);
            if (code != 0) begin
                chk("nop_on_error", out_insn, 32'h0000_0013);
            end else begin
                chk("opcode", 32'(out_insn[6:0]), 32'(e.op));
                chk("imm_roundtrip", dec_imm(e.op, out_insn), e.imm);
                if (!is_sb) chk("rd", 32'(out_insn[11:7]), 32'(e.rd));
                if (!is_uj) chk("rs1", 32'(out_insn[19:15]), 32'(e.rs1));
                if (!is_uj) chk("funct3", 32'(out_insn[14:12]), 32'(e.f3));
                if (is_sb)  chk("rs2", 32'(out_insn[24:20]), 32'(e.rs2));
            end
            if (has_exp) chk("insn_const", out_insn, exp_insn);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic model_reset();
        model_q.delete();
        model_addr = 32'h0;
        model_errs = 0;
    endtask

    initial begin
        logic [31:0] imm;
        int          batch;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        bnd = '{32'd2047, -32'd2048, 32'd2048, -32'd2049, 32'd4094, -32'd4096, 32'd4096,
                32'd4095, 32'd1048574, -32'd1048576, 32'd1048576, 32'h12345000, 32'h0, 32'd1};
        rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_rd = '0; req_rs1 = '0;
        req_rs2 = '0; req_funct3 = '0; req_imm = '0; addr_load = 1'b0;
        addr_load_val = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_insn", out_insn, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_code", 32'(out_err_code), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Basic encodings from the reference table.
        push_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        chk("fwft_latency", 32'(out_valid), 32'd1);
        push_req(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
        pop_chk(1'b1, 32'h0050_0093);
        pop_chk(1'b1, 32'h0020_A423);
        push_req(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'd4);
        push_req(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        push_req(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        pop_chk(1'b1, 32'hFE00_0EE3);
        pop_chk(1'b1, 32'h0010_00EF);
        pop_chk(1'b1, 32'h1234_52B7);

        // Error cases still consume addresses.
        push_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        push_req(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
        push_req(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        chk("err_cnt_three", 32'(err_cnt), 32'd3);
        pop_chk(1'b1, 32'h0000_0013);
        pop_chk(1'b0, 32'h0);
        pop_chk(1'b0, 32'h0);
        push_req(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 32'd1);
        pop_chk(1'b0, 32'h0);

        // Fill to depth, then one pop reopens the input.
        for (int i = 0; i < 4; i++) push_req(7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 32'(i));
        chk("full_not_ready", 32'(req_ready), 32'd0);
        pop_chk(1'b0, 32'h0);
        chk("ready_after_pop", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) pop_chk(1'b0, 32'h0);
        chk("drained_empty", 32'(out_valid), 32'd0);

        // Address load alone, then load coinciding with an accept.
        addr_load = 1'b1; addr_load_val = 32'h8;
        step();
        addr_load = 1'b0;
        model_addr = 32'h8;
        addr_load = 1'b1; addr_load_val = 32'h1003;
        push_req(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 32'd7);
        addr_load = 1'b0;
        push_req(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 32'd9);
        chk("load_tag_old", out_addr, 32'h8);
        pop_chk(1'b0, 32'h0);
        chk("load_tag_new", out_addr, 32'h1000);
        pop_chk(1'b0, 32'h0);

        // Flush with entries queued; a same-edge pop is ignored.
        for (int i = 0; i < 3; i++) push_req(7'h03, 5'd4, 5'd5, 5'd0, 3'd2, 32'(i * 4));
        flush = 1'b1;
        #1;
        chk("flush_blocks_ready", 32'(req_ready), 32'd0);
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        model_q.delete();
        push_req(7'h13, 5'd6, 5'd7, 5'd0, 3'd1, -32'd1);
        pop_chk(1'b0, 32'h0);

        // Randomized batches.
        for (int b = 0; b < 40; b++) begin
            batch = $urandom_range(1, 4);
            for (int k = 0; k < batch; k++) begin
                case ($urandom_range(0, 3))
                    0: imm = $urandom();
                    1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                    2: imm = bnd[$urandom_range(0, 13)];
                    default: imm = $urandom() & 32'hFFFF_F000;
                endcase
                push_req(ops[$urandom_range(0, 8)], 5'($urandom()), 5'($urandom()),
                         5'($urandom()), 3'($urandom()), imm);
            end
            for (int k = 0; k < batch; k++) pop_chk(1'b0, 32'h0);
        end
        chk("rand_err_cnt", 32'(err_cnt), 32'(model_errs));

        // Saturate the error counter.
        for (int i = 0; i < 256; i++) begin
            push_req(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
            pop_chk(1'b0, 32'h0);
        end
        chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // Reset mid-stream.
        push_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd11);
        push_req(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd12);
        rst_n = 1'b0;
        step();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_insn", out_insn, 32'h0);
        chk("mid_rst_out_addr", out_addr, 32'h0);
        chk("mid_rst_err_code", 32'(out_err_code), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        model_reset();
        push_req(7'h6F, 5'd3, 5'd0, 5'd0, 3'd0, -32'd1048576);
        chk("post_rst_addr", out_addr, 32'h0);
        pop_chk(1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
